ifu_fetch: RTL and testbench

Instruction fetch unit for the Tiny Vedas eBPF core. Issues in-order 64-bit instruction-slot reads to instruction memory, buffers the returned slots in a small credit-managed FIFO, and presents each slot with its byte PC as `instr_tag` to the decode stage. Handles stall back-pressure, pipeline flush with PC redirect, and discard of stale in-flight responses.

---
 rtl/ifu_fetch.sv | 120 ++++++++++++
 tb/tb_ifu_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the Tiny Vedas eBPF core.
//
// Issues in-order 64-bit slot reads to instruction memory, buffers returned
// slots in a credit-managed FIFO and presents the head slot with its byte PC.
// A request is only issued when the slot it will return into is guaranteed:
// outstanding + buffered < FIFO_DEPTH. On flush the FIFO is cleared, fetch
// restarts at redirect_pc, and every response still in flight is discarded.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   fetch_en                          permits new memory requests
//   imem_req_valid/ready/addr         instruction memory read request
//   imem_rsp_valid/data               in-order read response, no back-pressure
//   pipe_stall                        decode not consuming this cycle
//   pipe_flush, redirect_pc           discard everything, restart at redirect_pc
//   instr, instr_valid, instr_tag     FIFO head slot, non-empty flag, byte PC
module ifu_fetch #(
  parameter int              XLEN       = 64,
  parameter int              INSTR_LEN  = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [XLEN-1:0]      imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [INSTR_LEN-1:0] imem_rsp_data,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      pc;
  } slot_t;

  slot_t           mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, outstanding, drop_cnt, out_nxt;
  logic [XLEN-1:0] fetch_pc, rsp_pc, redir;
  logic [CW:0]     credits_used;
  logic            req_fire, push, pop;
  logic            unused_redir_lsb;

  assign redir            = {redirect_pc[XLEN-1:3], 3'b000};
  assign unused_redir_lsb = ^redirect_pc[2:0];

  // Every accepted-but-unreturned request owns a future FIFO slot.
  assign credits_used   = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = fetch_en & ~rst & ~pipe_flush &
                          (credits_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign push        = imem_rsp_valid & ~pipe_flush & (drop_cnt == '0);
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & ~pipe_stall & ~pipe_flush;
  assign instr       = mem[rd_ptr].instr;
  assign instr_tag   = mem[rd_ptr].pc;

  always_comb begin
    out_nxt = outstanding;
    if (req_fire)       out_nxt = out_nxt + CW'(1);
    if (imem_rsp_valid) out_nxt = out_nxt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      outstanding <= out_nxt;
      if (pipe_flush) begin
        fetch_pc <= redir;
        rsp_pc   <= redir;
        // Everything still in flight after this cycle is stale. Responses
        // already marked for dropping are part of outstanding, so the new
        // drop count is simply what remains outstanding; this keeps
        // back-to-back flushes from double-counting.
        drop_cnt <= out_nxt;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(8);
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          mem[wr_ptr] <= '{instr: imem_rsp_data, pc: rsp_pc};
          wr_ptr      <= wr_ptr + AW'(1);
          rsp_pc      <= rsp_pc + XLEN'(8);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  // The request credit check must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == CW'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h100;

  logic        clk = 1'b0;
  logic        rst, fetch_en, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        pipe_stall, pipe_flush, instr_valid;
  logic [63:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_tag;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(64), .INSTR_LEN(64), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
    .redirect_pc(redirect_pc), .instr(instr), .instr_valid(instr_valid),
    .instr_tag(instr_tag)
  );

  // Memory model: accepted requests waiting to return, tagged with the
  // flush epoch they were issued in. A response is useful only if it
  // belongs to the current epoch.
  typedef struct { logic [63:0] addr; int due; int ep; } mreq_t;
  mreq_t       memq[$];
  logic [63:0] mq[$];      // addresses of slots the fetch buffer should hold
  logic [63:0] exp_req;    // next address the unit should request
  logic [63:0] exp_pc;     // next PC decode should receive
  int ep = 0, cyc = 0, lat_lo = 1, lat_hi = 1;
  int checks = 0, errors = 0;

  function automatic logic [63:0] dat(input logic [63:0] a);
    return a ^ 64'h5A5A_0F0F_DEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    mreq_t r;
    @(negedge clk);
    if (rst) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      memq.delete(); mq.delete();
      ep = 0; exp_req = RPC; exp_pc = RPC;
    end else begin
      chk("req_valid", 64'(imem_req_valid),
          64'(fetch_en && !pipe_flush && (memq.size() + mq.size() < DEPTH)));
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      chk("instr_valid", 64'(instr_valid), 64'(mq.size() != 0));
      if (instr_valid && mq.size() != 0) begin
        chk("head_tag", instr_tag, mq[0]);
        chk("head_data", instr, dat(mq[0]));
      end
      if (instr_valid && !pipe_stall && !pipe_flush && mq.size() != 0) begin
        chk("pop_seq", instr_tag, exp_pc);
        exp_pc += 64'd8;
        void'(mq.pop_front());
      end
      if (imem_rsp_valid && memq.size() != 0) begin
        r = memq.pop_front();
        if (!pipe_flush && r.ep == ep) mq.push_back(r.addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        r.addr = imem_req_addr;
        r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        r.ep   = ep;
        memq.push_back(r);
        exp_req += 64'd8;
      end
      if (pipe_flush) begin
        ep++;
        mq.delete();
        exp_req = {redirect_pc[63:3], 3'b000};
        exp_pc  = exp_req;
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = dat(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = {$urandom, $urandom};
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !instr_valid; i++) tick();
    chk(tag, 64'(instr_valid), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; pipe_stall = 1'b0; pipe_flush = 1'b0; redirect_pc = '0;

    // Reset values.
    tick(); tick();
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", instr, 64'd0);
    chk("rst_tag", instr_tag, 64'd0);

    // Streaming from RESET_PC, first instr on cycle 3.
    rst = 1'b0;
    tick(); tick();
    chk("first_valid", 64'(instr_valid), 64'd1);
    chk("first_tag", instr_tag, 64'h100);
    repeat (10) tick();

    // Stall: buffer fills, credits run out, head holds.
    pipe_stall = 1'b1;
    repeat (10) tick();
    chk("stall_req_blocked", 64'(imem_req_valid), 64'd0);
    chk("stall_head", instr_tag, exp_pc);
    pipe_stall = 1'b0;
    repeat (8) tick();

    // 3-cycle memory, flush with responses outstanding.
    lat_lo = 3; lat_hi = 3;
    repeat (8) tick();
    pipe_flush = 1'b1; redirect_pc = 64'h2005;
    tick();
    pipe_flush = 1'b0;
    wait_valid("redir_valid");
    chk("redir_tag", instr_tag, 64'h2000);
    chk("redir_data", instr, dat(64'h2000));
    repeat (6) tick();

    // Flush coinciding with a response, then a second flush to 0x40.
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 20 && !imem_rsp_valid; i++) tick();
    chk("rsp_seen", 64'(imem_rsp_valid), 64'd1);
    pipe_flush = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_pc = 64'h40;
    tick();
    pipe_flush = 1'b0;
    wait_valid("flush2_valid");
    chk("flush2_tag", instr_tag, 64'h40);
    chk("flush2_data", instr, dat(64'h40));
    repeat (6) tick();

    // Memory not ready: address holds; then fetch disabled: buffer drains.
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b0;
    repeat (5) tick();
    chk("hold_valid", 64'(imem_req_valid), 64'd1);
    chk("hold_addr", imem_req_addr, exp_req);
    imem_req_ready = 1'b1; fetch_en = 1'b0;
    repeat (12) tick();
    chk("drain_valid", 64'(instr_valid), 64'd0);
    chk("drain_req", 64'(imem_req_valid), 64'd0);
    fetch_en = 1'b1;

    // Address wrap at the top of the address space.
    pipe_flush = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    pipe_flush = 1'b0;
    wait_valid("wrap_valid");
    chk("wrap_tag0", instr_tag, 64'hFFFF_FFFF_FFFF_FFF0);
    tick();
    chk("wrap_tag1", instr_tag, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("wrap_tag2", instr_tag, 64'h0);
    repeat (4) tick();

    // Random traffic.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      pipe_stall     = ($urandom_range(2, 0) == 0);
      imem_req_ready = ($urandom_range(3, 0) != 0);
      fetch_en       = ($urandom_range(7, 0) != 0);
      pipe_flush     = ($urandom_range(29, 0) == 0);
      redirect_pc    = {$urandom, $urandom};
      tick();
    end
    pipe_flush = 1'b0; pipe_stall = 1'b0;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
